// File: rtl/booth_dot_accum_if.sv
// Bundles the product-in and result-out handshakes of the Booth dot-product
// accumulator. The master drives jobs and products; the slave is the accumulator.
interface booth_dot_accum_if #(
    parameter int N     = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    prod_valid;
    logic                    prod_ready;
    logic signed [2*N-1:0]   Product;
    logic                    acc_valid;
    logic                    acc_ready;
    logic signed [ACC_W-1:0] Acc;
    logic                    overflow;
    logic                    busy;

    modport master (
        output start, len, prod_valid, Product, acc_ready,
        input  prod_ready, acc_valid, Acc, overflow, busy
    );

    modport slave (
        input  start, len, prod_valid, Product, acc_ready,
        output prod_ready, acc_valid, Acc, overflow, busy
    );
endinterface

// File: rtl/booth_dot_accum.sv
// Sums a fixed-length stream of signed Booth products into a saturating
// signed accumulator and hands the result out over a valid/ready handshake.
module booth_dot_accum #(
    parameter int N     = 16,
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input logic               clk,
    input logic               rst,
    booth_dot_accum_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    overflow_q;
    logic [LEN_W-1:0]        count_q;
    logic                    prod_ready_q;
    logic                    acc_valid_q;
    logic                    busy_q;

    logic signed [ACC_W:0]   sum_d;
    logic signed [ACC_W-1:0] acc_d;
    logic                    sat_hi_d;
    logic                    sat_lo_d;
    logic                    transfer_d;

    // One guard bit is enough because ACC_W >= 2N: the two top bits of the
    // widened sum disagree exactly when the true sum left the ACC_W range.
    always_comb begin
        sum_d      = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-2*N){bus.Product[2*N-1]}}, bus.Product};
        sat_hi_d   = (sum_d[ACC_W:ACC_W-1] == 2'b01);
        sat_lo_d   = (sum_d[ACC_W:ACC_W-1] == 2'b10);
        acc_d      = sum_d[ACC_W-1:0];
        if (sat_hi_d) begin
            acc_d = ACC_MAX;
        end else if (sat_lo_d) begin
            acc_d = ACC_MIN;
        end
        transfer_d = bus.prod_valid & prod_ready_q;
    end

    // Handshake outputs are registered and updated together with the state,
    // so they always reflect the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
            prod_ready_q <= 1'b0;
            acc_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        acc_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.len != '0) begin
                            count_q      <= bus.len;
                            prod_ready_q <= 1'b1;
                            state_q      <= ACCUM;
                        end else begin
                            acc_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (transfer_d) begin
                        acc_q   <= acc_d;
                        count_q <= count_q - 1'b1;
                        if (sat_hi_d || sat_lo_d) begin
                            overflow_q <= 1'b1;
                        end
                        if (count_q == LEN_W'(1)) begin
                            prod_ready_q <= 1'b0;
                            acc_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.acc_ready) begin
                        acc_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    prod_ready_q <= 1'b0;
                    acc_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.Acc        = acc_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;
endmodule
